// File: rtl/cnt_modn_scan_pkg.sv
// cnt_modn_scan_pkg
//   Shared constants for the cascaded modulo-N counter with display scan.
//   Holds the default geometry (digit count, modulus, digit width, scan
//   divider), the count-direction encoding and a helper that sizes index
//   counters so that a range of 1 still gets a legal 1-bit register.
package cnt_modn_scan_pkg;

    localparam int DEF_DIGITS   = 4;
    localparam int DEF_MOD      = 10;
    // Digit width. This is also the width of the slice SCAN_DIG pulls out
    // of CNTVAL, so the two can never disagree.
    localparam int DEF_W        = 4;
    localparam int DEF_SCAN_DIV = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnt_modn_scan_if.sv
// cnt_modn_scan_if
//   Control/status bundle of the counter.
//   master : drives CLR, LOAD, LDVAL, EN, UP; observes the outputs.
//   slave  : the counter itself; drives CNTVAL, OV, SCAN_SEL, SCAN_DIG.
//   LDVAL/CNTVAL pack digit i at [i*W +: W], digit 0 least significant.
interface cnt_modn_scan_if #(
    parameter int DIGITS = cnt_modn_scan_pkg::DEF_DIGITS,
    parameter int W      = cnt_modn_scan_pkg::DEF_W
) ();

    logic                  CLR;
    logic                  LOAD;
    logic [DIGITS*W-1:0]   LDVAL;
    logic                  EN;
    logic                  UP;
    logic [DIGITS*W-1:0]   CNTVAL;
    logic                  OV;
    logic [DIGITS-1:0]     SCAN_SEL;
    logic [W-1:0]          SCAN_DIG;

    modport master (
        output CLR, LOAD, LDVAL, EN, UP,
        input  CNTVAL, OV, SCAN_SEL, SCAN_DIG
    );

    modport slave (
        input  CLR, LOAD, LDVAL, EN, UP,
        output CNTVAL, OV, SCAN_SEL, SCAN_DIG
    );

endinterface

// File: rtl/cnt_modn_scan_digit.sv
// cnt_digit
//   One modulo-MOD up/down digit.
//   CLK, RST   : clock, asynchronous active-high reset (VAL -> 0)
//   CLR        : synchronous clear, highest synchronous priority
//   LOAD, LDV  : synchronous load, stored as given (no range check)
//   STEP       : advance one position in direction UP
//   VAL        : registered digit value
//   CY, BW     : this digit wraps on a step (up past MOD-1 / down past 0);
//                combinational, already qualified by UP
module cnt_digit
    import cnt_modn_scan_pkg::*;
#(
    parameter int MOD = DEF_MOD,
    parameter int W   = DEF_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    input  logic         LOAD,
    input  logic [W-1:0] LDV,
    input  logic         STEP,
    input  logic         UP,
    output logic [W-1:0] VAL,
    output logic         CY,
    output logic         BW
);

    // Compare in W+1 bits since the modulus may equal 2**W.
    localparam logic [W:0]   MOD_X  = (W+1)'(MOD);
    localparam logic [W:0]   LAST_X = (W+1)'(MOD - 1);
    localparam logic [W-1:0] LAST   = W'(MOD - 1);

    logic [W-1:0] val_q;
    logic [W-1:0] val_nxt;
    logic [W:0]   val_x;
    logic         at_top;
    logic         at_zero;
    logic         over;
    logic         up_dir;

    assign val_x   = {1'b0, val_q};
    assign at_top  = (val_x >= LAST_X);   // includes out-of-range loads
    assign at_zero = (val_q == '0);
    assign over    = (val_x >= MOD_X);
    assign up_dir  = (dir_e'(UP) == DIR_UP);

    assign CY = up_dir & at_top;
    // An out-of-range digit counting down snaps to MOD-1 without borrowing.
    assign BW = ~up_dir & at_zero;

    always_comb begin
        val_nxt = val_q;
        if (up_dir)
            val_nxt = at_top ? '0 : val_q + W'(1);
        else if (at_zero || over)
            val_nxt = LAST;
        else
            val_nxt = val_q - W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            val_q <= '0;
        else if (CLR)
            val_q <= '0;
        else if (LOAD)
            val_q <= LDV;
        else if (STEP)
            val_q <= val_nxt;
    end

    assign VAL = val_q;

endmodule

// File: rtl/cnt_modn_scan.sv
// cnt_modn_scan
//   DIGITS cascaded modulo-MOD up/down digits plus a multiplexed-display
//   scanner.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave side of cnt_modn_scan_if
//     CLR/LOAD/LDVAL/EN/UP : counter control (priority CLR > LOAD > EN)
//     CNTVAL               : registered packed count
//     OV                   : combinational "whole counter wraps this edge"
//     SCAN_SEL             : registered one-hot digit select
//     SCAN_DIG             : combinational value of the selected digit
module cnt_modn_scan
    import cnt_modn_scan_pkg::*;
#(
    parameter int DIGITS   = DEF_DIGITS,
    parameter int MOD      = DEF_MOD,
    parameter int W        = DEF_W,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic           CLK,
    input  logic           RST,
    cnt_modn_scan_if.slave bus
);

    logic [DIGITS-1:0][W-1:0] vals;
    logic [DIGITS-1:0]        cy;
    logic [DIGITS-1:0]        bw;
    logic [DIGITS-1:0]        wrap;
    logic [DIGITS-1:0]        step;

    // ------------------------------------------------------------------
    // Counter chain. A digit steps when EN is high and every lower digit
    // wraps in the current direction; CY/BW are already UP-qualified, so
    // their OR is the direction-correct ripple term.
    // ------------------------------------------------------------------
    assign step[0] = bus.EN;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign wrap[i] = cy[i] | bw[i];
        if (i > 0) begin : g_chain
            assign step[i] = step[i-1] & wrap[i-1];
        end

        cnt_digit #(
            .MOD (MOD),
            .W   (W)
        ) u_digit (
            .CLK  (CLK),
            .RST  (RST),
            .CLR  (bus.CLR),
            .LOAD (bus.LOAD),
            .LDV  (bus.LDVAL[i*W +: W]),
            .STEP (step[i]),
            .UP   (bus.UP),
            .VAL  (vals[i]),
            .CY   (cy[i]),
            .BW   (bw[i])
        );
    end

    assign bus.CNTVAL = vals;

    // Top digit stepping and wrapping implies every digit wraps.
    assign bus.OV = bus.EN & ~bus.CLR & ~bus.LOAD
                  & step[DIGITS-1] & wrap[DIGITS-1];

    // ------------------------------------------------------------------
    // Display scan: free-running, unaffected by EN/CLR/LOAD.
    // ------------------------------------------------------------------
    if (DIGITS == 1) begin : g_scan1
        assign bus.SCAN_SEL = 1'b1;
        assign bus.SCAN_DIG = vals[0];
    end else begin : g_scanN
        localparam int PW = idx_bits(SCAN_DIV);
        localparam int IW = idx_bits(DIGITS);
        localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
        localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

        logic [PW-1:0]     pre_q;
        logic [IW-1:0]     idx_q;
        logic [DIGITS-1:0] sel_q;
        logic              tick;

        assign tick = (pre_q == PRE_LAST);

        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                pre_q <= '0;
            else if (tick)
                pre_q <= '0;
            else
                pre_q <= pre_q + PW'(1);
        end

        // Index and one-hot select move together so SCAN_SEL is a plain
        // register rather than a decoder output.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                idx_q <= '0;
                sel_q <= DIGITS'(1);
            end else if (tick) begin
                if (idx_q == IDX_LAST) begin
                    idx_q <= '0;
                    sel_q <= DIGITS'(1);
                end else begin
                    idx_q <= idx_q + IW'(1);
                    sel_q <= sel_q << 1;
                end
            end
        end

        assign bus.SCAN_SEL = sel_q;
        assign bus.SCAN_DIG = vals[idx_q];
    end

endmodule

// File: tb/tb_cnt_modn_scan.sv
// tb_cnt_modn_scan
//   Directed bench for cnt_modn_scan at DIGITS=4, MOD=10, W=4, SCAN_DIV=4.
module tb_cnt_modn_scan;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int checks = 0;
    int errors = 0;

    cnt_modn_scan_if #(.DIGITS(4), .W(4)) bus ();

    cnt_modn_scan #(
        .DIGITS   (4),
        .MOD      (10),
        .W        (4),
        .SCAN_DIV (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int n);
        logic [15:0] r;
        int v;
        r = '0;
        v = n;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Advance one edge; sample 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ctl(input logic clr, input logic load,
                           input logic [15:0] ldv, input logic en,
                           input logic up);
        bus.CLR   = clr;
        bus.LOAD  = load;
        bus.LDVAL = ldv;
        bus.EN    = en;
        bus.UP    = up;
    endtask

    initial begin
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset state
        #12;
        chk("rst_cnt", 32'(bus.CNTVAL), 32'h0000);
        chk("rst_ov",  32'(bus.OV), 32'h0);
        chk("rst_sel", 32'(bus.SCAN_SEL), 32'h1);
        chk("rst_dig", 32'(bus.SCAN_DIG), 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Full up count 0000..9999 and wrap
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        #1;
        for (int n = 0; n < 10000; n++) begin
            chk("up_cnt", 32'(bus.CNTVAL), 32'(bcd(n)));
            chk("up_ov",  32'(bus.OV), (n == 9999) ? 32'h1 : 32'h0);
            tick();
        end
        chk("up_wrap", 32'(bus.CNTVAL), 32'h0000);

        // Down from 0000
        set_ctl(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        chk("dn_cnt0", 32'(bus.CNTVAL), 32'h0000);
        chk("dn_ov0",  32'(bus.OV), 32'h1);
        tick();
        chk("dn_cnt1", 32'(bus.CNTVAL), 32'h9999);
        chk("dn_ov1",  32'(bus.OV), 32'h0);
        tick();
        chk("dn_cnt2", 32'(bus.CNTVAL), 32'h9998);
        chk("dn_ov2",  32'(bus.OV), 32'h0);

        // Out-of-range digit 1 counting up
        set_ctl(1'b0, 1'b1, 16'h00F0, 1'b0, 1'b1);
        tick();
        chk("oor_ld", 32'(bus.CNTVAL), 32'h00F0);
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++) tick();
        chk("oor_f9",  32'(bus.CNTVAL), 32'h00F9);
        chk("oor_ov",  32'(bus.OV), 32'h0);
        tick();
        chk("oor_100", 32'(bus.CNTVAL), 32'h0100);

        // Out-of-range digit 0 counting down: snaps to 9 with no borrow
        set_ctl(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        chk("oor_dn_ov", 32'(bus.OV), 32'h0);
        tick();
        chk("oor_dn", 32'(bus.CNTVAL), 32'h0009);

        // Priority: CLR over LOAD over EN
        set_ctl(1'b0, 1'b1, 16'h0123, 1'b0, 1'b1);
        tick();
        chk("pri_ld", 32'(bus.CNTVAL), 32'h0123);
        set_ctl(1'b1, 1'b1, 16'h0789, 1'b1, 1'b1);
        #1;
        chk("pri_ov_clr", 32'(bus.OV), 32'h0);
        tick();
        chk("pri_clr", 32'(bus.CNTVAL), 32'h0000);
        set_ctl(1'b0, 1'b1, 16'h0456, 1'b1, 1'b1);
        tick();
        chk("pri_load", 32'(bus.CNTVAL), 32'h0456);

        // Hold, then UP change taking effect on its own edge
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        tick();
        chk("hold", 32'(bus.CNTVAL), 32'h0456);
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        chk("up1", 32'(bus.CNTVAL), 32'h0457);
        bus.UP = 1'b0;
        tick();
        chk("dn1", 32'(bus.CNTVAL), 32'h0456);

        // Scan sequence after a fresh reset, counter loaded with 4321
        @(negedge CLK);
        RST = 1'b1;
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        @(negedge CLK);
        RST = 1'b0;
        set_ctl(1'b0, 1'b1, 16'h4321, 1'b0, 1'b1);
        #1;
        for (int k = 0; k < 40; k++) begin
            int j;
            j = (k / 4) % 4;
            chk("scan_sel", 32'(bus.SCAN_SEL), 32'(1) << j);
            chk("scan_dig", 32'(bus.SCAN_DIG), (k == 0) ? 32'h0 : 32'(j + 1));
            tick();
            bus.LOAD = 1'b0;
        end

        // Asynchronous reset mid count / mid scan step
        set_ctl(1'b0, 1'b1, 16'h0537, 1'b0, 1'b1);
        tick();
        set_ctl(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        chk("ar_pre", 32'(bus.CNTVAL), 32'h0537);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_cnt", 32'(bus.CNTVAL), 32'h0000);
        chk("ar_sel", 32'(bus.SCAN_SEL), 32'h1);
        chk("ar_ov",  32'(bus.OV), 32'h0);
        chk("ar_dig", 32'(bus.SCAN_DIG), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        bus.EN = 1'b1;
        tick();
        chk("ar_first", 32'(bus.CNTVAL), 32'h0001);
        chk("ar_sel1",  32'(bus.SCAN_SEL), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
